// File: rtl/keyed_sequence_checker.sv
// Key-locked sequence checker: tracks a DEPTH-step pattern on x, diverts onto a
// never-matching decoy path on wrong key bits, and locks out after THRESH decoy steps.
module keyed_sequence_checker #(
    parameter int                 W           = 10,
    parameter int                 DEPTH       = 4,
    parameter logic [DEPTH*W-1:0] PATTERN     = '0,
    parameter int                 KW          = 4,
    parameter logic [KW-1:0]      CORRECT_KEY = 4'b1010,
    parameter int                 CW          = 8,
    parameter int                 THRESH      = 5,
    localparam int                IW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  x,
    input  logic [KW-1:0] keyinput,
    output logic          y_hit,
    output logic          y_err,
    output logic          y_match,
    output logic          y_locked,
    output logic [IW-1:0] y_idx,
    output logic [CW-1:0] dcnt
);

    typedef enum logic [2:0] {
        IDLE,
        TRACK,
        DECOY,
        DONE,
        LOCK
    } mode_e;

    localparam logic [CW-1:0] DCNT_MAX = '1;

    mode_e         mode_q, mode_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] dcnt_q, dcnt_d;

    logic [W-1:0]  stepWord;
    logic          keyOk;
    logic          xHit;
    logic          lastStep;
    logic          incReq;

    // Pattern word and key bit for the current step; idx reaches DEPTH only in DONE.
    always_comb begin
        stepWord = '0;
        keyOk    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx_q == IW'(i)) begin
                stepWord = PATTERN[i*W +: W];
                keyOk    = (keyinput[i % KW] == CORRECT_KEY[i % KW]);
            end
        end
        xHit     = (x == stepWord);
        lastStep = (idx_q == IW'(DEPTH - 1));
    end

    always_comb begin
        mode_d   = mode_q;
        idx_d    = idx_q;
        dcnt_d   = dcnt_q;
        incReq   = 1'b0;
        y_hit    = 1'b0;
        y_err    = 1'b0;
        y_match  = 1'b0;
        y_locked = 1'b0;

        case (mode_q)
            IDLE, TRACK: begin
                y_hit = xHit;
                if (xHit) begin
                    if (keyOk) begin
                        if (lastStep) begin
                            mode_d = DONE;
                            idx_d  = IW'(DEPTH);
                        end else begin
                            mode_d = TRACK;
                            idx_d  = idx_q + IW'(1);
                        end
                    end else begin
                        incReq = 1'b1;
                        if (lastStep) begin
                            mode_d = IDLE;
                            idx_d  = '0;
                        end else begin
                            mode_d = DECOY;
                            idx_d  = idx_q + IW'(1);
                        end
                    end
                end else if (mode_q == TRACK) begin
                    y_err  = 1'b1;
                    mode_d = IDLE;
                    idx_d  = '0;
                end
            end
            DECOY: begin
                y_hit = xHit;
                if (xHit) begin
                    incReq = 1'b1;
                    if (lastStep) begin
                        mode_d = IDLE;
                        idx_d  = '0;
                    end else begin
                        idx_d  = idx_q + IW'(1);
                    end
                end else begin
                    y_err  = 1'b1;
                    mode_d = IDLE;
                    idx_d  = '0;
                end
            end
            DONE: begin
                y_match = 1'b1;
                mode_d  = IDLE;
                idx_d   = '0;
            end
            LOCK: begin
                y_locked = 1'b1;
            end
            default: begin
                mode_d = IDLE;
                idx_d  = '0;
            end
        endcase

        // Decoy counting saturates; reaching the threshold overrides any other next state.
        if (incReq) begin
            if (dcnt_q != DCNT_MAX) begin
                dcnt_d = dcnt_q + CW'(1);
            end
            if ((THRESH != 0) && (int'(dcnt_d) == THRESH)) begin
                mode_d = LOCK;
                idx_d  = '0;
            end
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= IDLE;
            idx_q  <= '0;
            dcnt_q <= '0;
        end else begin
            mode_q <= mode_d;
            idx_q  <= idx_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign y_idx = (mode_q == LOCK) ? '0 : idx_q;
    assign dcnt  = dcnt_q;

endmodule

// File: tb/tb_keyed_sequence_checker.sv
// Directed bench for keyed_sequence_checker: a lockout instance (THRESH=2) and two
// non-locking instances (THRESH=0, CW=8 and CW=4) sharing one stimulus stream.
module tb_keyed_sequence_checker;

    localparam int                 W     = 4;
    localparam int                 DEPTH = 3;
    localparam int                 KW    = 2;
    localparam logic [KW-1:0]      CKEY  = 2'b10;
    localparam logic [DEPTH*W-1:0] PAT   = {4'h5, 4'hA, 4'h3};

    typedef struct {
        logic [3:0] x;
        logic [1:0] key;
        logic       hit;
        logic       err;
        logic       match;
        logic       locked;
        logic [1:0] idx;
        logic [7:0] dcnt;
    } vecT;

    logic       clk = 1'b0;
    logic       rstA, rstB;
    logic [3:0] xA, xB;
    logic [1:0] keyA, keyB;
    logic       hitA, errA, matchA, lockedA;
    logic       hitB, errB, matchB, lockedB;
    logic       hitC, errC, matchC, lockedC;
    logic [1:0] idxA, idxB, idxC;
    logic [7:0] dcntA, dcntB;
    logic [3:0] dcntC;

    int total = 0;
    int bad   = 0;
    vecT tbl[21];

    always #5 clk = ~clk;

    keyed_sequence_checker #(.W(W), .DEPTH(DEPTH), .PATTERN(PAT), .KW(KW),
        .CORRECT_KEY(CKEY), .CW(8), .THRESH(2)) dutA (
        .clk(clk), .rst(rstA), .x(xA), .keyinput(keyA),
        .y_hit(hitA), .y_err(errA), .y_match(matchA), .y_locked(lockedA),
        .y_idx(idxA), .dcnt(dcntA));

    keyed_sequence_checker #(.W(W), .DEPTH(DEPTH), .PATTERN(PAT), .KW(KW),
        .CORRECT_KEY(CKEY), .CW(8), .THRESH(0)) dutB (
        .clk(clk), .rst(rstB), .x(xB), .keyinput(keyB),
        .y_hit(hitB), .y_err(errB), .y_match(matchB), .y_locked(lockedB),
        .y_idx(idxB), .dcnt(dcntB));

    keyed_sequence_checker #(.W(W), .DEPTH(DEPTH), .PATTERN(PAT), .KW(KW),
        .CORRECT_KEY(CKEY), .CW(4), .THRESH(0)) dutC (
        .clk(clk), .rst(rstB), .x(xB), .keyinput(keyB),
        .y_hit(hitC), .y_err(errC), .y_match(matchC), .y_locked(lockedC),
        .y_idx(idxC), .dcnt(dcntC));

    function automatic vecT mkVec(input logic [3:0] x, input logic [1:0] k,
                                  input logic h, input logic e, input logic m,
                                  input logic l, input logic [1:0] i,
                                  input logic [7:0] d);
        vecT v;
        v.x = x; v.key = k; v.hit = h; v.err = e;
        v.match = m; v.locked = l; v.idx = i; v.dcnt = d;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one vector just after a falling edge, check Mealy/Moore outputs at the
    // rising edge, then let the falling edge commit the step.
    task automatic applyStimulus(input vecT v, input string tag);
        xA   = v.x;
        keyA = v.key;
        @(posedge clk);
        checkOutput({tag, " hit"},    32'(hitA),    32'(v.hit));
        checkOutput({tag, " err"},    32'(errA),    32'(v.err));
        checkOutput({tag, " match"},  32'(matchA),  32'(v.match));
        checkOutput({tag, " locked"}, 32'(lockedA), 32'(v.locked));
        checkOutput({tag, " idx"},    32'(idxA),    32'(v.idx));
        checkOutput({tag, " dcnt"},   32'(dcntA),   32'(v.dcnt));
        @(negedge clk);
        #1;
    endtask

    // Pull reset low between edges and expect the reset state without any clock edge.
    task automatic pulseResetA(input string tag, input logic expHit);
        #2 rstA = 1'b0;
        #1;
        checkOutput({tag, " idx"},    32'(idxA),    32'd0);
        checkOutput({tag, " dcnt"},   32'(dcntA),   32'd0);
        checkOutput({tag, " locked"}, 32'(lockedA), 32'd0);
        checkOutput({tag, " match"},  32'(matchA),  32'd0);
        checkOutput({tag, " err"},    32'(errA),    32'd0);
        checkOutput({tag, " hit"},    32'(hitA),    32'(expHit));
        @(negedge clk);
        #1 rstA = 1'b1;
        #1;
    endtask

    task automatic applyB(input logic [3:0] x, input logic [1:0] k, input logic expHit,
                          input logic [1:0] expIdx, input int expB, input int expC,
                          input string tag);
        xB   = x;
        keyB = k;
        @(posedge clk);
        checkOutput({tag, " hitB"},    32'(hitB),    32'(expHit));
        checkOutput({tag, " hitC"},    32'(hitC),    32'(expHit));
        checkOutput({tag, " errB"},    32'(errB),    32'd0);
        checkOutput({tag, " matchB"},  32'(matchB),  32'd0);
        checkOutput({tag, " matchC"},  32'(matchC),  32'd0);
        checkOutput({tag, " lockedB"}, 32'(lockedB), 32'd0);
        checkOutput({tag, " lockedC"}, 32'(lockedC), 32'd0);
        checkOutput({tag, " idxB"},    32'(idxB),    32'(expIdx));
        checkOutput({tag, " dcntB"},   32'(dcntB),   32'(expB));
        checkOutput({tag, " dcntC"},   32'(dcntC),   32'(expC));
        @(negedge clk);
        #1;
    endtask

    initial begin
        // x, key, hit, err, match, locked, idx, dcnt (state before the falling edge)
        tbl[0]  = mkVec(4'h3, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        tbl[1]  = mkVec(4'hA, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0);
        tbl[2]  = mkVec(4'h5, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 8'd0);
        tbl[3]  = mkVec(4'h0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 8'd0);
        tbl[4]  = mkVec(4'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        tbl[5]  = mkVec(4'h3, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        tbl[6]  = mkVec(4'hA, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0);
        tbl[7]  = mkVec(4'h7, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0);
        tbl[8]  = mkVec(4'h3, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        tbl[9]  = mkVec(4'h5, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0);
        tbl[10] = mkVec(4'h3, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        tbl[11] = mkVec(4'h7, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1);
        tbl[12] = mkVec(4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);
        tbl[13] = mkVec(4'h3, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);
        tbl[14] = mkVec(4'hA, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1);
        tbl[15] = mkVec(4'h5, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 8'd1);
        tbl[16] = mkVec(4'h3, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 8'd1);
        tbl[17] = mkVec(4'h3, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);
        tbl[18] = mkVec(4'h3, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd2);
        tbl[19] = mkVec(4'hA, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd2);
        tbl[20] = mkVec(4'h5, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd2);

        rstA = 1'b0; rstB = 1'b0;
        xA = 4'h3; keyA = 2'b10;
        xB = 4'h0; keyB = 2'b11;
        #1;
        checkOutput("reset idx",    32'(idxA),    32'd0);
        checkOutput("reset dcnt",   32'(dcntA),   32'd0);
        checkOutput("reset match",  32'(matchA),  32'd0);
        checkOutput("reset err",    32'(errA),    32'd0);
        checkOutput("reset locked", 32'(lockedA), 32'd0);
        checkOutput("reset hit",    32'(hitA),    32'd1);
        checkOutput("reset hitB",   32'(hitB),    32'd0);
        @(negedge clk);
        #2 rstA = 1'b1; rstB = 1'b1;

        for (int i = 0; i < 21; i++) begin
            applyStimulus(tbl[i], $sformatf("row%0d", i));
        end

        // Reset out of LOCK, then the plain lockout sequence from a clean counter.
        pulseResetA("lockexit", 1'b0);
        applyStimulus(mkVec(4'h3, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0), "lk0");
        applyStimulus(mkVec(4'hA, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1), "lk1");
        applyStimulus(mkVec(4'h3, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd2), "lk2");
        applyStimulus(mkVec(4'hA, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd2), "lk3");
        applyStimulus(mkVec(4'h5, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd2), "lk4");
        pulseResetA("lockrst", 1'b0);

        // Abort a correct-key run two steps in, then run it cleanly.
        applyStimulus(mkVec(4'h3, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0), "ab0");
        applyStimulus(mkVec(4'hA, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0), "ab1");
        xA = 4'h5;
        pulseResetA("midrst", 1'b0);
        applyStimulus(mkVec(4'h3, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0), "re0");
        applyStimulus(mkVec(4'hA, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0), "re1");
        applyStimulus(mkVec(4'h5, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 8'd0), "re2");
        applyStimulus(mkVec(4'h0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 8'd0), "re3");
        applyStimulus(mkVec(4'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0), "re4");

        // Ten full decoy runs without lockout; the 4-bit counter saturates at 15.
        for (int r = 0; r < 10; r++) begin
            for (int s = 0; s < 3; s++) begin
                logic [3:0] xs;
                int         cnt;
                xs  = PAT[s*W +: W];
                cnt = 3 * r + s;
                applyB(xs, 2'b11, 1'b1, 2'(s), cnt, (cnt > 15) ? 15 : cnt,
                       $sformatf("dec%0d.%0d", r, s));
            end
        end
        applyB(4'h0, 2'b11, 1'b0, 2'd0, 30, 15, "decEnd");

        // Wrong key only on step 1: correct start, diverted to the decoy at idx 2.
        applyB(4'h3, 2'b00, 1'b1, 2'd0, 30, 15, "late0");
        applyB(4'hA, 2'b00, 1'b1, 2'd1, 30, 15, "late1");
        applyB(4'h5, 2'b00, 1'b1, 2'd2, 31, 15, "late2");
        applyB(4'h0, 2'b00, 1'b0, 2'd0, 32, 15, "late3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
